// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: shared types, FSM state encodings and parity helper for the configurable UART transmitter.
package uart_tx_cfg_pkg;
  localparam int DIV_RATIO = 8;
  typedef enum bit {PAR_EVEN, PAR_ODD} uart_par_e;
  typedef logic [2:0] UART_TX_CFG_e;
  localparam UART_TX_CFG_e IDLE      = 3'd0;
  localparam UART_TX_CFG_e START_BIT = 3'd1;
  localparam UART_TX_CFG_e SENDING   = 3'd2;
  localparam UART_TX_CFG_e PARITY    = 3'd3;
  localparam UART_TX_CFG_e END_BIT   = 3'd4;
  function automatic logic par_of(input logic xor_red, input uart_par_e typ);
    return xor_red ^ (typ == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with synchronous clear and terminal-count pulse.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i & (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: LSB-first UART transmitter with per-word parity/stop config and a one-word holding buffer.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DIV_RATIO
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  Ready,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Frame_Done
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  UART_TX_CFG_e state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [2:0] hcfg_q, hcfg_d;
  logic full_q, full_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic pe_q, pe_d, par_q, par_d, s2_q, s2_d, stop_q, stop_d, tx_q, tx_d;
  logic accept, load, done, tick, clr;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (state_q != IDLE),
    .clr_i (clr),
    .tick_o(tick)
  );
  assign accept     = Data_Valid & ~full_q;
  assign Ready      = ~full_q;
  assign Busy       = (state_q != IDLE) | full_q;
  assign TX_OUT     = tx_q;
  assign Frame_Done = done;
  always_comb begin
    full_d = accept | (full_q & ~load);
    hold_d = accept ? P_DATA : hold_q;
    hcfg_d = accept ? {PAR_EN, PAR_TYP, STOP2} : hcfg_q;
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (full_q) begin
        load    = 1'b1;
        state_d = START_BIT;
      end
      START_BIT: if (tick) begin
        state_d = SENDING;
        idx_d   = '0;
      end
      SENDING: if (tick) begin
        if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
          state_d = pe_q ? PARITY : END_BIT;
          stop_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (tick) begin
        state_d = END_BIT;
        stop_d  = 1'b0;
      end
      END_BIT: if (tick) begin
        if (stop_q == s2_q) begin
          done    = 1'b1;
          load    = full_q;
          state_d = full_q ? START_BIT : IDLE;
        end else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) shift_d = hold_q;
  end
  // frame config is captured together with the word so mid-frame input changes cannot leak in
  always_comb begin
    pe_d  = load ? hcfg_q[2] : pe_q;
    par_d = load ? par_of(^hold_q, uart_par_e'(hcfg_q[1])) : par_q;
    s2_d  = load ? hcfg_q[0] : s2_q;
    clr   = (state_d == START_BIT) & (state_q != START_BIT);
    tx_d  = (state_d == START_BIT) ? 1'b0 :
            (state_d == SENDING)   ? shift_d[0] :
            (state_d == PARITY)    ? par_q : 1'b1;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      hcfg_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      pe_q    <= 1'b0;
      par_q   <= 1'b0;
      s2_q    <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hcfg_q  <= hcfg_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      pe_q    <= pe_d;
      par_q   <= par_d;
      s2_q    <= s2_d;
      tx_q    <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench; expected frames queued at send time, checked bit-by-bit by a line monitor.
module tb_uart_tx_cfg;
  localparam int CPB = 4;
  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       s2;
  } frame_t;
  logic CLK, RST, Data_Valid, PAR_EN, PAR_TYP, STOP2;
  logic [7:0] P_DATA;
  logic Ready, TX_OUT, Busy, Frame_Done;
  int total = 0, bad = 0, cyc = 0, nframes = 0, rdy_cyc = 0, lows = 0;
  int start_cyc[8], end_cyc[8], done_len[8];
  frame_t exp_q[$];
  uart_tx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Ready(Ready),
    .TX_OUT(TX_OUT), .Busy(Busy), .Frame_Done(Frame_Done)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic exp_bit(input frame_t f, input int c);
    int b;
    b = (c - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.d[b-1];
    if (b == 9 && f.pe) return f.pt ? ~^f.d : ^f.d;
    return 1'b1;
  endfunction
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    frame_t f;
    for (int k = 0; k < 2000 && !Ready; k++) @(negedge CLK);
    check("send_ready", Ready, 1);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_Valid = 1'b1;
    f = '{d: d, pe: pe, pt: pt, s2: s2};
    exp_q.push_back(f);
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask
  task automatic wait_frames(input int n);
    for (int k = 0; k < 3000 && nframes < n; k++) @(negedge CLK);
    if (nframes < n) check("timeout_frames", nframes, n);
  endtask
  initial begin : mon
    frame_t f;
    int len, st, da;
    forever begin
      @(negedge CLK);
      if (!RST && TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) check("spurious_frame", 1, 0);
        else begin
          f = exp_q.pop_front();
          len = (2 + 8 + int'(f.pe) + int'(f.s2)) * CPB;
          st = cyc;
          da = 0;
          for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge CLK);
            if (RST) break;
            check("tx_bit", TX_OUT, exp_bit(f, c));
            check("frame_done", Frame_Done, c == len);
            if (Frame_Done) da = c;
            if (c == len && nframes < 8) begin
              start_cyc[nframes] = st;
              end_cyc[nframes]   = cyc;
              done_len[nframes]  = da;
              nframes++;
            end
          end
        end
      end
    end
  end
  initial begin
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", Busy, 0);
    check("rst_ready", Ready, 1);
    check("rst_done", Frame_Done, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    send(8'hA5, 1, 0, 0);
    check("acc_ready", Ready, 0);
    check("acc_busy", Busy, 1);
    wait_frames(1);
    check("a5_len", done_len[0], 44);
    @(negedge CLK);
    check("a5_idle_busy", Busy, 0);
    check("a5_idle_tx", TX_OUT, 1);
    send(8'h01, 1, 1, 1);
    wait_frames(2);
    check("01_len", done_len[1], 48);
    send(8'h55, 0, 0, 0);
    repeat (10) @(negedge CLK);
    send(8'hFF, 0, 0, 0);
    check("held_ready", Ready, 0);
    P_DATA = 8'h33; PAR_EN = 1'b1; STOP2 = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int k = 0; k < 2000 && !Ready; k++) @(negedge CLK);
    rdy_cyc = cyc;
    wait_frames(4);
    check("55_len", done_len[2], 40);
    check("ff_len", done_len[3], 40);
    check("b2b_gap", start_cyc[3], end_cyc[2] + 1);
    check("ready_rise", rdy_cyc, start_cyc[3]);
    repeat (5) @(negedge CLK);
    send(8'hA5, 0, 0, 0);
    for (int k = 0; k < 100 && TX_OUT !== 1'b0; k++) @(negedge CLK);
    check("rs_start", TX_OUT, 0);
    repeat (17) @(negedge CLK);
    check("rs_bit3", TX_OUT, 0);
    #2 RST = 1'b1;
    #1;
    check("rs_tx", TX_OUT, 1);
    check("rs_busy", Busy, 0);
    check("rs_ready", Ready, 1);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1) lows++;
    end
    check("rs_idle_line", lows, 0);
    check("rs_idle_busy", Busy, 0);
    check("frames_total", nframes, 4);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
